// File: rtl/mem_stage_bus.sv
// mem_stage_bus: pipeline memory-access stage between exe_mem and mem_wb.
// Talks to the system bus with req/ack/err, stalls upstream while an access
// is in flight, reports misalignment, bus faults and timeouts as exceptions.
//
//   state | meaning
//   IDLE  | accepting instructions; ALU ops and misaligned ops retire here
//   BUSY  | bus access in flight, upstream stalled, waiting for ack/timeout
module mem_stage_bus #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [3:0]              mem_op_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
  input  logic                    reg_we_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic                    bus_ack_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_err_i,
  output logic                    valid_o,
  output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
  output logic                    reg_we_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic                    exc_o,
  output logic [2:0]              exc_cause_o
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  // Latched access; sz encodes 0 byte, 1 half, 2 word, 3 double.
  logic                   st_q, sgn_q, we_q, flush_q;
  logic [1:0]             sz_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q, alu_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic [TW-1:0]          tmr;

  logic       dec_mem, dec_st, dec_sgn, dec_mis;
  logic [1:0] dec_sz;

  // Decode the incoming op; 64-bit ops collapse to NONE on a 32-bit bus.
  always_comb begin
    dec_mem = 1'b0;
    dec_st  = 1'b0;
    dec_sgn = 1'b0;
    dec_sz  = 2'd0;
    case (mem_op_i)
      4'd1:  begin dec_mem = 1'b1; dec_sgn = 1'b1; end
      4'd2:  begin dec_mem = 1'b1; dec_sgn = 1'b1; dec_sz = 2'd1; end
      4'd3:  begin dec_mem = 1'b1; dec_sgn = 1'b1; dec_sz = 2'd2; end
      4'd4:  dec_mem = 1'b1;
      4'd5:  begin dec_mem = 1'b1; dec_sz = 2'd1; end
      4'd6:  begin dec_mem = 1'b1; dec_st = 1'b1; end
      4'd7:  begin dec_mem = 1'b1; dec_st = 1'b1; dec_sz = 2'd1; end
      4'd8:  begin dec_mem = 1'b1; dec_st = 1'b1; dec_sz = 2'd2; end
      4'd9:  if (DATA_WIDTH == 64) begin dec_mem = 1'b1; dec_sz = 2'd2; end
      4'd10: if (DATA_WIDTH == 64) begin dec_mem = 1'b1; dec_sgn = 1'b1; dec_sz = 2'd3; end
      4'd11: if (DATA_WIDTH == 64) begin dec_mem = 1'b1; dec_st = 1'b1; dec_sz = 2'd3; end
      default: ;
    endcase
    case (dec_sz)
      2'd1:    dec_mis = mem_addr_i[0];
      2'd2:    dec_mis = |mem_addr_i[1:0];
      2'd3:    dec_mis = |mem_addr_i[2:0];
      default: dec_mis = 1'b0;
    endcase
  end

  logic [NB-1:0]         be_base;
  logic [DATA_WIDTH-1:0] sz_mask, lane, ld_val;
  logic                  sbit;

  // Lane positioning for stores and lane extraction/extension for loads.
  always_comb begin
    case (sz_q)
      2'd0:    begin be_base = NB'(1);  sz_mask = DATA_WIDTH'(8'hFF); end
      2'd1:    begin be_base = NB'(3);  sz_mask = DATA_WIDTH'(16'hFFFF); end
      2'd2:    begin be_base = NB'(15); sz_mask = DATA_WIDTH'(32'hFFFF_FFFF); end
      default: begin be_base = '1;      sz_mask = '1; end
    endcase
    lane = bus_rdata_i >> {addr_q[OFFW-1:0], 3'b000};
    case (sz_q)
      2'd0:    sbit = lane[7];
      2'd1:    sbit = lane[15];
      2'd2:    sbit = lane[31];
      default: sbit = lane[DATA_WIDTH-1];
    endcase
    ld_val = (lane & sz_mask) | ((sgn_q && sbit) ? ~sz_mask : '0);
  end

  logic busy;
  assign busy        = (state == BUSY);
  assign stall_o     = busy;
  assign bus_req_o   = busy;
  assign bus_we_o    = busy & st_q;
  assign bus_addr_o  = busy ? {addr_q[ADDR_WIDTH-1:OFFW], OFFW'(0)} : '0;
  assign bus_be_o    = busy ? (be_base << addr_q[OFFW-1:0]) : '0;
  assign bus_wdata_o = (busy && st_q) ? ((data_q & sz_mask) << {addr_q[OFFW-1:0], 3'b000}) : '0;

  // Control FSM with registered single-cycle result pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      st_q        <= 1'b0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      flush_q     <= 1'b0;
      sz_q        <= 2'd0;
      addr_q      <= '0;
      data_q      <= '0;
      alu_q       <= '0;
      waddr_q     <= '0;
      tmr         <= '0;
      valid_o     <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      exc_o       <= 1'b0;
      exc_cause_o <= 3'd0;
    end else begin
      valid_o     <= 1'b0;
      reg_we_o    <= 1'b0;
      exc_o       <= 1'b0;
      exc_cause_o <= 3'd0;
      case (state)
        IDLE: begin
          if (valid_i && !flush_i) begin
            if (!dec_mem) begin
              valid_o     <= 1'b1;
              reg_we_o    <= reg_we_i;
              reg_waddr_o <= reg_waddr_i;
              reg_wdata_o <= reg_wdata_i;
            end else if (dec_mis) begin
              valid_o     <= 1'b1;
              exc_o       <= 1'b1;
              exc_cause_o <= dec_st ? 3'd2 : 3'd1;
              reg_waddr_o <= reg_waddr_i;
            end else begin
              state   <= BUSY;
              st_q    <= dec_st;
              sgn_q   <= dec_sgn;
              sz_q    <= dec_sz;
              addr_q  <= mem_addr_i;
              data_q  <= mem_data_i;
              alu_q   <= reg_wdata_i;
              waddr_q <= reg_waddr_i;
              we_q    <= reg_we_i;
              flush_q <= 1'b0;
              tmr     <= TO_LOAD;
            end
          end
        end
        BUSY: begin
          if (flush_i) flush_q <= 1'b1;
          if (bus_ack_i) begin
            state <= IDLE;
            if (!(flush_q || flush_i)) begin
              valid_o     <= 1'b1;
              reg_waddr_o <= waddr_q;
              if (bus_err_i) begin
                exc_o       <= 1'b1;
                exc_cause_o <= st_q ? 3'd4 : 3'd3;
              end else begin
                reg_we_o    <= we_q;
                reg_wdata_o <= st_q ? alu_q : ld_val;
              end
            end
          end else if (TIMEOUT_CYCLES != 0 && tmr == '0) begin
            state <= IDLE;
            if (!(flush_q || flush_i)) begin
              valid_o     <= 1'b1;
              reg_waddr_o <= waddr_q;
              exc_o       <= 1'b1;
              exc_cause_o <= 3'd5;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus: a 32-bit instance (short timeout) and a
// 64-bit instance, results checked against an expected-result queue.
module tb_mem_stage_bus;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_we, a_flush, a_ack, a_err;
  logic [3:0]  a_op;
  logic [31:0] a_addr, a_data, a_wd_in, a_rdata;
  logic [4:0]  a_waddr;
  logic        a_stall, a_req, a_bwe, a_vo, a_we_o, a_exc;
  logic [31:0] a_baddr, a_bwdata, a_wdata_o;
  logic [3:0]  a_be;
  logic [4:0]  a_waddr_o;
  logic [2:0]  a_cause;

  logic        b_valid, b_we, b_flush, b_ack, b_err;
  logic [3:0]  b_op;
  logic [31:0] b_addr;
  logic [63:0] b_data, b_wd_in, b_rdata;
  logic [4:0]  b_waddr;
  logic        b_stall, b_req, b_bwe, b_vo, b_we_o, b_exc;
  logic [31:0] b_baddr;
  logic [63:0] b_bwdata, b_wdata_o;
  logic [7:0]  b_be;
  logic [4:0]  b_waddr_o;
  logic [2:0]  b_cause;

  mem_stage_bus #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(8)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .mem_op_i(a_op), .mem_addr_i(a_addr),
    .mem_data_i(a_data), .reg_waddr_i(a_waddr), .reg_we_i(a_we), .reg_wdata_i(a_wd_in),
    .flush_i(a_flush), .stall_o(a_stall), .bus_req_o(a_req), .bus_we_o(a_bwe),
    .bus_addr_o(a_baddr), .bus_be_o(a_be), .bus_wdata_o(a_bwdata), .bus_ack_i(a_ack),
    .bus_rdata_i(a_rdata), .bus_err_i(a_err), .valid_o(a_vo), .reg_waddr_o(a_waddr_o),
    .reg_we_o(a_we_o), .reg_wdata_o(a_wdata_o), .exc_o(a_exc), .exc_cause_o(a_cause));

  mem_stage_bus #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(8)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .mem_op_i(b_op), .mem_addr_i(b_addr),
    .mem_data_i(b_data), .reg_waddr_i(b_waddr), .reg_we_i(b_we), .reg_wdata_i(b_wd_in),
    .flush_i(b_flush), .stall_o(b_stall), .bus_req_o(b_req), .bus_we_o(b_bwe),
    .bus_addr_o(b_baddr), .bus_be_o(b_be), .bus_wdata_o(b_bwdata), .bus_ack_i(b_ack),
    .bus_rdata_i(b_rdata), .bus_err_i(b_err), .valid_o(b_vo), .reg_waddr_o(b_waddr_o),
    .reg_we_o(b_we_o), .reg_wdata_o(b_wdata_o), .exc_o(b_exc), .exc_cause_o(b_cause));

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        exc;
    logic [2:0]  cause;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input logic we, input logic [4:0] wa,
                      input logic [63:0] wd, input logic exc, input logic [2:0] cause);
    exp_t e;
    e.we = we; e.waddr = wa; e.wdata = wd; e.exc = exc; e.cause = cause;
    if (!sel) qa.push_back(e);
    else      qb.push_back(e);
  endtask

  // Result monitors: every valid_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_vo) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 64'(a_vo), 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_exc", 64'(a_exc), 64'(e.exc));
        chk("a_cause", 64'(a_cause), 64'(e.cause));
        chk("a_reg_we", 64'(a_we_o), 64'(e.we));
        chk("a_waddr", 64'(a_waddr_o), 64'(e.waddr));
        if (e.we) chk("a_wdata", 64'(a_wdata_o), e.wdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_vo) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 64'(b_vo), 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_exc", 64'(b_exc), 64'(e.exc));
        chk("b_cause", 64'(b_cause), 64'(e.cause));
        chk("b_reg_we", 64'(b_we_o), 64'(e.we));
        chk("b_waddr", 64'(b_waddr_o), 64'(e.waddr));
        if (e.we) chk("b_wdata", b_wdata_o, e.wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle (DUT is expected to be IDLE).
  task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                       input logic [63:0] data, input logic [4:0] wa, input logic we,
                       input logic [63:0] wd);
    if (!sel) begin
      a_valid = 1'b1; a_op = op; a_addr = addr; a_data = data[31:0];
      a_waddr = wa; a_we = we; a_wd_in = wd[31:0];
    end else begin
      b_valid = 1'b1; b_op = op; b_addr = addr; b_data = data;
      b_waddr = wa; b_we = we; b_wd_in = wd;
    end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Hold ack low for 'waits' cycles, then ack once; counts stalled cycles.
  task automatic bus_resp(input bit sel, input int waits, input logic [63:0] rd,
                          input logic err, output int stall_cnt);
    stall_cnt = 0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        if (!sel) begin a_ack = 1'b1; a_rdata = rd[31:0]; a_err = err; end
        else      begin b_ack = 1'b1; b_rdata = rd;       b_err = err; end
      end
      @(negedge clk);
      if (sel ? b_stall : a_stall) stall_cnt++;
      tick();
    end
    a_ack = 1'b0; a_err = 1'b0;
    b_ack = 1'b0; b_err = 1'b0;
  endtask

  initial begin
    int sc;
    rst = 1'b1;
    a_valid = 0; a_op = 0; a_addr = 0; a_data = 0; a_wd_in = 0; a_waddr = 0; a_we = 0;
    a_flush = 0; a_ack = 0; a_err = 0; a_rdata = 0;
    b_valid = 0; b_op = 0; b_addr = 0; b_data = 0; b_wd_in = 0; b_waddr = 0; b_we = 0;
    b_flush = 0; b_ack = 0; b_err = 0; b_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(a_stall), 64'd0);
    chk("rst_req", 64'(a_req), 64'd0);
    chk("rst_valid", 64'(a_vo), 64'd0);
    chk("rst_exc", 64'(a_exc), 64'd0);
    chk("rst_be", 64'(a_be), 64'd0);
    chk("rst_b_req", 64'(b_req), 64'd0);
    rst = 1'b0;
    tick();

    // LW with three wait cycles
    push(0, 1, 5'd5, 64'hDEAD_BEEF, 0, 3'd0);
    issue(0, 4'd3, 32'h100, 64'd0, 5'd5, 1'b1, 64'd0);
    #1;
    chk("lw_req", 64'(a_req), 64'd1);
    chk("lw_be", 64'(a_be), 64'hF);
    chk("lw_addr", 64'(a_baddr), 64'h100);
    chk("lw_bus_we", 64'(a_bwe), 64'd0);
    bus_resp(0, 3, 64'hDEAD_BEEF, 1'b0, sc);
    chk("lw_stall_cycles", 64'(sc), 64'd4);
    @(negedge clk);
    chk("lw_valid_next", 64'(a_vo), 64'd1);
    chk("lw_req_low", 64'(a_req), 64'd0);

    // sub-word loads
    push(0, 1, 5'd6, 64'hFFFF_FF80, 0, 3'd0);
    issue(0, 4'd1, 32'h103, 64'd0, 5'd6, 1'b1, 64'd0);
    #1;
    chk("lb_be", 64'(a_be), 64'h8);
    bus_resp(0, 1, 64'h80FF_0000, 1'b0, sc);
    push(0, 1, 5'd7, 64'h0000_80FF, 0, 3'd0);
    issue(0, 4'd5, 32'h102, 64'd0, 5'd7, 1'b1, 64'd0);
    #1;
    chk("lhu_be", 64'(a_be), 64'hC);
    bus_resp(0, 0, 64'h80FF_0000, 1'b0, sc);
    chk("lhu_min_occupancy", 64'(sc), 64'd1);

    // sub-word store
    push(0, 0, 5'd8, 64'd0, 0, 3'd0);
    issue(0, 4'd7, 32'h202, 64'h1234, 5'd8, 1'b0, 64'd0);
    #1;
    chk("sh_be", 64'(a_be), 64'hC);
    chk("sh_wdata", 64'(a_bwdata), 64'h1234_0000);
    chk("sh_bus_we", 64'(a_bwe), 64'd1);
    chk("sh_addr", 64'(a_baddr), 64'h200);
    bus_resp(0, 2, 64'd0, 1'b0, sc);

    // misaligned load and store
    push(0, 0, 5'd9, 64'd0, 1, 3'd1);
    issue(0, 4'd3, 32'h101, 64'd0, 5'd9, 1'b1, 64'd0);
    #1;
    chk("mis_lw_req", 64'(a_req), 64'd0);
    chk("mis_lw_stall", 64'(a_stall), 64'd0);
    push(0, 0, 5'd9, 64'd0, 1, 3'd2);
    issue(0, 4'd7, 32'h201, 64'h55, 5'd9, 1'b1, 64'd0);
    #1;
    chk("mis_sh_req", 64'(a_req), 64'd0);

    // store acked with bus error
    push(0, 0, 5'd10, 64'd0, 1, 3'd4);
    issue(0, 4'd8, 32'h300, 64'hCAFE, 5'd10, 1'b1, 64'd0);
    bus_resp(0, 1, 64'd0, 1'b1, sc);

    // timeout with no ack
    push(0, 0, 5'd11, 64'd0, 1, 3'd5);
    issue(0, 4'd3, 32'h400, 64'd0, 5'd11, 1'b1, 64'd0);
    sc = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_req) sc++;
      tick();
    end
    chk("timeout_req_cycles", 64'(sc), 64'd8);

    // flushed load with an ALU op waiting behind it
    issue(0, 4'd3, 32'h500, 64'd0, 5'd12, 1'b1, 64'd0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_valid = 1'b1; a_op = 4'd0; a_waddr = 5'd13; a_we = 1'b1; a_wd_in = 32'h55;
    push(0, 1, 5'd13, 64'h55, 0, 3'd0);
    a_ack = 1'b1; a_rdata = 32'h1111_2222;
    tick();
    a_ack = 1'b0;
    @(negedge clk);
    chk("flush_valid_low", 64'(a_vo), 64'd0);
    chk("flush_stall_low", 64'(a_stall), 64'd0);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("alu_after_ack_valid", 64'(a_vo), 64'd1);

    // LD on the 32-bit instance is a plain ALU op
    push(0, 1, 5'd15, 64'h77, 0, 3'd0);
    issue(0, 4'd10, 32'h4, 64'd0, 5'd15, 1'b1, 64'h77);
    #1;
    chk("ld32_no_req", 64'(a_req), 64'd0);

    // async reset in the middle of an access
    tick();
    issue(0, 4'd3, 32'h600, 64'd0, 5'd14, 1'b1, 64'd0);
    #1;
    chk("pre_rst_req", 64'(a_req), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_req", 64'(a_req), 64'd0);
    chk("async_rst_stall", 64'(a_stall), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 64-bit instance
    push(1, 0, 5'd1, 64'd0, 0, 3'd0);
    issue(1, 4'd11, 32'h8, 64'h1122_3344_5566_7788, 5'd1, 1'b0, 64'd0);
    #1;
    chk("sd_be", 64'(b_be), 64'hFF);
    chk("sd_addr", 64'(b_baddr), 64'h8);
    chk("sd_wdata", b_bwdata, 64'h1122_3344_5566_7788);
    chk("sd_bus_we", 64'(b_bwe), 64'd1);
    bus_resp(1, 1, 64'd0, 1'b0, sc);
    push(1, 1, 5'd2, 64'h0000_0000_8000_0001, 0, 3'd0);
    issue(1, 4'd9, 32'hC, 64'd0, 5'd2, 1'b1, 64'd0);
    #1;
    chk("lwu_be", 64'(b_be), 64'hF0);
    chk("lwu_addr", 64'(b_baddr), 64'h8);
    bus_resp(1, 0, 64'h8000_0001_0000_0000, 1'b0, sc);
    push(1, 1, 5'd3, 64'hFFFF_FFFF_8000_0001, 0, 3'd0);
    issue(1, 4'd3, 32'hC, 64'd0, 5'd3, 1'b1, 64'd0);
    bus_resp(1, 0, 64'h8000_0001_0000_0000, 1'b0, sc);
    push(1, 0, 5'd4, 64'd0, 1, 3'd1);
    issue(1, 4'd10, 32'h4, 64'd0, 5'd4, 1'b1, 64'd0);
    #1;
    chk("mis_ld_req", 64'(b_req), 64'd0);

    repeat (3) tick();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
